booth_job_sequencer: RTL
========================

# booth_job_sequencer

Operand-issue and result-capture stage wrapped around the Booth multiplier. Accepts signed operand pairs on a valid/ready input, buffers up to two jobs, and drives the multiplier's `start` and shared load bus in the cycle order its control path expects: multiplicand first, multiplier second. It captures the 2·WIDTH product on `done` and holds it on a valid/ready output. A watchdog converts a missing `done` into an error result.

## Interface
- `WIDTH`, default 16: operand width; the product is 2·WIDTH bits.
- `TIMEOUT`, default 3·WIDTH+8: maximum WAIT cycles before an error result is returned.
- `FLUSH_CYC`, default WIDTH+4: post-reset/post-error quiet cycles before any `mul_start`.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept.
- `in_a` in WIDTH: multiplicand (signed).
- `in_b` in WIDTH: multiplier (signed).
- `mul_start` out 1: start pulse to the multiplier control path.
- `mul_data` out WIDTH: multiplier datapath load bus.
- `mul_done` in 1: multiplier done.
- `mul_product` in 2·WIDTH: multiplier {A,Q} result, valid while `mul_done`=1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_product` out 2·WIDTH: captured product (two's complement).
- `out_err` out 1: result produced by timeout.
- `busy` out 1: state ≠ IDLE.

## Operation
- **Operand FIFO:** 2 entries, stores {a,b}.
  - `in_ready` = (count≠2) and `rst_n`.
  - Push on `in_valid`&&`in_ready`; pop at the LOADQ→WAIT edge.
  - Push and pop in the same edge keeps count unchanged.
  - Data accepted while `in_ready`=0 is ignored.
- **FSM states:** FLUSH, IDLE, START, LOADM, LOADQ, WAIT, OUT.
  - FLUSH: counts `FLUSH_CYC` cycles, then goes to IDLE. `mul_done` is ignored. Entered on reset and after an error handshake.
  - IDLE: if count>0, go to START.
  - START: `mul_start`=1, `mul_data`=head.a. Always goes to LOADM.
  - LOADM: `mul_data`=head.a; the multiplier loads M at this cycle's end. Goes to LOADQ.
  - LOADQ: `mul_data`=head.b; the multiplier loads Q. Pop FIFO, go to WAIT, clear watchdog.
  - WAIT: watchdog increments each cycle.
    - `mul_done`=1: capture `mul_product` into `out_product`, `out_err`=0, go to OUT.
    - Watchdog = TIMEOUT−1 with no `mul_done`: `out_product`=0, `out_err`=1, go to OUT.
  - OUT: `out_valid`=1. Hold `out_product` and `out_err` stable until `out_valid`&&`out_ready`. On that handshake:
    - `out_err`=1: go to FLUSH.
    - else count>0: go to START.
    - else: go to IDLE.
- `mul_done` outside WAIT is ignored, with no state or output change.
- `mul_data` is 0 in every state except START, LOADM and LOADQ.
- The product is captured verbatim. No sign or width manipulation.

## Timing
- **Reset** (`rst_n` low at an edge) has these values after that edge:
  - state=FLUSH, FLUSH counter=0, FIFO count=0, watchdog=0.
  - `mul_start`=0, `mul_data`=0, `out_valid`=0, `out_err`=0, `out_product`=0, `busy`=1.
  - `in_ready`=0 while `rst_n` is low.
- Reset mid-job drops all FIFO contents and any pending result. The FLUSH period lets an in-flight multiply finish unobserved.
- All outputs except `in_ready` are registered state decodes, with no combinational path from any input. `in_ready` is decoded from the registered count and `rst_n`.
- **Accept to start:**
  - Push at edge E with the FSM in IDLE: START in cycle E+1, `mul_start` high for exactly 1 cycle.
  - M is loaded at the end of START+1 and Q at the end of START+2.
- **Done to result:** `mul_done` sampled at edge D gives `out_valid`=1 in the cycle after D.
- **Back-to-back:** a handshake at edge H with count>0 puts START in cycle H+1.
- **Timeout:** exactly TIMEOUT WAIT cycles elapse before `out_valid`.

## Test plan
- WIDTH=16: push a=3, b=5 with a behavioural Booth model attached.
  - Expect `mul_start` for 1 cycle, `mul_data`=3,3,5 over START/LOADM/LOADQ.
  - Expect `out_product`=32'h0000000F, `out_err`=0.
- Push a=−7, b=6. Expect `out_product`=32'hFFFFFFD6. Push a=−32768, b=−32768. Expect 32'h40000000.
- Push 3 jobs on consecutive cycles while job 1 is in WAIT.
  - `in_ready` drops after 2 buffered entries.
  - Results appear in order, and each START follows its OUT handshake by 1 cycle.
- Hold `out_ready`=0 for 10 cycles in OUT, pulsing `mul_done` meanwhile.
  - `out_valid`, `out_product` and `out_err` stay stable; the stray `mul_done` is ignored.
  - The handshake then completes.
- Stub multiplier with no `mul_done`.
  - After 56 WAIT cycles (WIDTH=16): `out_valid`=1, `out_err`=1, `out_product`=0.
  - After the handshake: FLUSH for 20 cycles with no `mul_start`.
- Assert `rst_n`=0 for 1 cycle during WAIT with 1 job queued, and inject `mul_done` 5 cycles later.
  - `mul_done` is ignored, the FIFO is empty, `out_valid` stays 0.
  - A new job pushed after FLUSH completes normally.

Source files
------------

// File: rtl/booth_job_sequencer.sv
// Operand-issue / result-capture sequencer for the Booth multiplier:
// two-entry operand FIFO, start/load sequencing, product capture and a done watchdog.
module booth_job_sequencer #(
    parameter int WIDTH     = 16,
    parameter int TIMEOUT   = 3*WIDTH+8,
    parameter int FLUSH_CYC = WIDTH+4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_data,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_err,
    output logic               busy
);

    localparam int WD_W = $clog2(TIMEOUT+1);
    localparam int FL_W = $clog2(FLUSH_CYC+1);

    typedef enum logic [2:0] {
        S_FLUSH, S_IDLE, S_START, S_LOADM, S_LOADQ, S_WAIT, S_OUT
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] fifo_a [2];
    logic [WIDTH-1:0] fifo_b [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic [FL_W-1:0]  flush_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             push, pop, timeout_hit;

    assign in_ready    = (count != 2'd2) && rst_n;
    assign push        = in_valid && in_ready;
    assign pop         = (state == S_LOADQ);
    assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT-1));

    always_comb begin
        state_nx = state;
        case (state)
            S_FLUSH: if (flush_cnt == FL_W'(FLUSH_CYC-1)) state_nx = S_IDLE;
            // A push in this very cycle lands in the FIFO head by the START cycle
            S_IDLE:  if (count != 2'd0 || push) state_nx = S_START;
            S_START: state_nx = S_LOADM;
            S_LOADM: state_nx = S_LOADQ;
            S_LOADQ: state_nx = S_WAIT;
            S_WAIT:  if (mul_done || timeout_hit) state_nx = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    if (out_err)              state_nx = S_FLUSH;
                    else if (count != 2'd0)   state_nx = S_START;
                    else                      state_nx = S_IDLE;
                end
            end
            default: state_nx = S_FLUSH;
        endcase
    end

    always_comb begin
        mul_start = (state == S_START);
        out_valid = (state == S_OUT);
        busy      = (state != S_IDLE);
        case (state)
            S_START, S_LOADM: mul_data = fifo_a[rd_ptr];
            S_LOADQ:          mul_data = fifo_b[rd_ptr];
            default:          mul_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FLUSH;
            flush_cnt   <= '0;
            wd_cnt      <= '0;
            count       <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            out_product <= '0;
            out_err     <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
            else                  flush_cnt <= '0;

            if (state == S_LOADQ)     wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;

            // Result registers only move on the WAIT exit, so OUT holds them stable
            if (state == S_WAIT) begin
                if (mul_done) begin
                    out_product <= mul_product;
                    out_err     <= 1'b0;
                end else if (timeout_hit) begin
                    out_product <= '0;
                    out_err     <= 1'b1;
                end
            end

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
